// File: rtl/frame_feed_ctrl.sv
// Streams pixels into a ping-pong source buffer, dispatches full banks to the inference
// engine and queues its results. Define FRAME_FEED_WDOG_EN to enable the engine watchdog.
module frame_feed_ctrl #(
  parameter int PIX_W     = 8,
  parameter int FRAME_W   = 32,
  parameter int FRAME_H   = 32,
  parameter int ADDR_W    = $clog2(FRAME_W * FRAME_H),
  parameter int RES_W     = 4,
  parameter int RES_DEPTH = 4,
  parameter int WDOG_CYC  = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              buf_we,
  output logic [ADDR_W:0]   buf_wa,
  output logic [PIX_W-1:0]  buf_wd,
  output logic              eng_bank,
  output logic              go,
  input  logic              ready,
  input  logic [RES_W-1:0]  digit,
  output logic              r_valid,
  output logic [RES_W:0]    r_data,
  input  logic              r_ready,
  output logic [31:0]       frame_cnt,
  output logic              len_err,
  output logic              wdog_err
);

  localparam int N   = FRAME_W * FRAME_H;
  localparam int PW  = $clog2(RES_DEPTH);
  localparam int PW1 = PW + 1;
  localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(N - 1);
  localparam logic [PW:0]       DEPTH_FULL = PW1'(RES_DEPTH);
  localparam logic [PW:0]       DEPTH_LAST = PW1'(RES_DEPTH - 1);

  typedef enum logic {E_IDLE = 1'b0, E_WAIT = 1'b1} eng_state_t;

  eng_state_t          r_state;
  logic [1:0]          r_full;
  logic                r_fill_bank;
  logic [ADDR_W-1:0]   r_pix_cnt;
  logic                r_eng_bank;
  logic                r_go;
  logic                r_buf_we;
  logic [ADDR_W:0]     r_buf_wa;
  logic [PIX_W-1:0]    r_buf_wd;
  logic [31:0]         r_frame_cnt;
  logic                r_len_err;
  logic [RES_W:0]      r_mem [RES_DEPTH];
  logic [PW-1:0]       r_wp;
  logic [PW-1:0]       r_rp;
  logic [PW:0]         r_fifo_cnt;

  logic                w_s_ready;
  logic                w_acc;
  logic                w_at_last;
  logic                w_close;
  logic                w_pop;
  logic                w_wdog_exp;
  logic                w_done;
  logic                w_space_idle;
  logic                w_chain;
  logic [RES_W:0]      w_res_data;
  logic [1:0]          w_full_set;
  logic [1:0]          w_full_clr;

  assign w_s_ready    = !rst && !r_full[r_fill_bank];
  assign w_acc        = s_valid && w_s_ready;
  assign w_at_last    = (r_pix_cnt == LAST_PIX);
  assign w_close      = w_acc && (w_at_last || s_last);
  assign w_pop        = r_ready && (r_fifo_cnt != '0);
  assign w_done       = (r_state == E_WAIT) && (ready || w_wdog_exp);
  assign w_space_idle = (r_fifo_cnt < DEPTH_FULL) || w_pop;
  // Retiring one bank while the other is already full restarts the engine without an idle cycle
  assign w_chain      = r_full[~r_eng_bank] && ((r_fifo_cnt < DEPTH_LAST) || w_pop);
  assign w_full_set   = w_close ? {r_fill_bank, ~r_fill_bank} : 2'b00;
  assign w_full_clr   = w_done  ? {r_eng_bank, ~r_eng_bank}   : 2'b00;

`ifdef FRAME_FEED_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC) + 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYC - 1);

  logic [WW-1:0] r_wdog_cnt;
  logic          r_wdog_err;

  // A ready arriving on the expiry cycle takes priority over the timeout result
  assign w_wdog_exp = (r_state == E_WAIT) && !ready && (r_wdog_cnt == WDOG_LAST);
  assign w_res_data = ready ? {1'b0, digit} : {1'b1, {RES_W{1'b1}}};
  assign wdog_err   = r_wdog_err;

  // Watchdog: counts cycles of each dispatched frame, sticky error on expiry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      if (r_state != E_WAIT || w_done) r_wdog_cnt <= '0;
      else r_wdog_cnt <= r_wdog_cnt + WW'(1);
      if (w_wdog_exp) r_wdog_err <= 1'b1;
    end
  end
`else
  assign w_wdog_exp = 1'b0;
  assign w_res_data = {1'b0, digit};
  assign wdog_err   = 1'b0;
`endif

  // Fill side: registered buffer write port, pixel counter and bank toggle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill_bank <= 1'b0;
      r_pix_cnt   <= '0;
      r_buf_we    <= 1'b0;
      r_buf_wa    <= '0;
      r_buf_wd    <= '0;
      r_len_err   <= 1'b0;
    end else begin
      r_buf_we <= w_acc;
      if (w_acc) begin
        r_buf_wa <= {r_fill_bank, r_pix_cnt};
        r_buf_wd <= s_data;
      end
      if (w_close) begin
        r_fill_bank <= ~r_fill_bank;
        r_pix_cnt   <= '0;
      end else if (w_acc) begin
        r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
      end
      if (w_acc && (s_last != w_at_last)) r_len_err <= 1'b1;
    end
  end

  // Bank occupancy: fill and engine always touch different banks, so both apply
  always_ff @(posedge clk) begin
    if (rst) r_full <= 2'b00;
    else r_full <= (r_full & ~w_full_clr) | w_full_set;
  end

  // Engine dispatch FSM: start a full bank when the result FIFO has room, retire on result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= E_IDLE;
      r_eng_bank  <= 1'b0;
      r_go        <= 1'b0;
      r_frame_cnt <= 32'd0;
    end else begin
      r_go <= 1'b0;
      case (r_state)
        E_IDLE: begin
          if (r_full[r_eng_bank] && w_space_idle) begin
            r_go    <= 1'b1;
            r_state <= E_WAIT;
          end else begin
            r_state <= E_IDLE;
          end
        end
        E_WAIT: begin
          if (w_done) begin
            r_eng_bank  <= ~r_eng_bank;
            r_frame_cnt <= r_frame_cnt + 32'd1;
            if (w_chain) begin
              r_go    <= 1'b1;
              r_state <= E_WAIT;
            end else begin
              r_state <= E_IDLE;
            end
          end else begin
            r_state <= E_WAIT;
          end
        end
        default: r_state <= E_IDLE;
      endcase
    end
  end

  // Show-ahead result FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RES_DEPTH; i++) r_mem[i] <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_done) begin
        r_mem[r_wp] <= w_res_data;
        r_wp        <= r_wp + PW'(1);
      end
      if (w_pop) r_rp <= r_rp + PW'(1);
      case ({w_done, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + PW1'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - PW1'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  assign s_ready   = w_s_ready;
  assign buf_we    = r_buf_we;
  assign buf_wa    = r_buf_wa;
  assign buf_wd    = r_buf_wd;
  assign eng_bank  = r_eng_bank;
  assign go        = r_go;
  assign r_valid   = (r_fifo_cnt != '0);
  assign r_data    = r_mem[r_rp];
  assign frame_cnt = r_frame_cnt;
  assign len_err   = r_len_err;

endmodule
